// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit packetizer.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic logic [15:0] words_to_bytes(input logic [15:0] words);
    return words * 16'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/udp_tx_buf.sv
// Simple dual-port word buffer with a registered, read-enabled output port.
module udp_tx_buf #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register holds its value when no read is requested.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/udp_tx_packer.sv
// Cuts a 32-bit word stream into UDP payloads and drives the UDP transmitter handshake.
// Optional idle-flush of partial packets is compiled in with `define UDP_TX_TIMEOUT_EN.
module udp_tx_packer
  import udp_tx_pkg::*;
#(
  parameter int unsigned PKT_WORDS   = 256,
  parameter int unsigned BUF_AW      = 10,
  parameter int unsigned LEN_AW      = 2,
  parameter int unsigned TIMEOUT_CYC = 125000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        udp_tx_done,
  output logic        busy
);

  localparam int unsigned     LQ_DEPTH = 2**LEN_AW;
  localparam logic [BUF_AW:0] PKT_LEN  = (BUF_AW+1)'(PKT_WORDS);

  logic [BUF_AW:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_AW:0] acc_q, acc_d, acc_inc;
  logic [LEN_AW:0] lq_wr_q, lq_rd_q;
  logic [BUF_AW:0] lq_mem_q [LQ_DEPTH];
  logic            rdy_q;

  logic            buf_full, lq_full, lq_empty;
  logic            wr_fire, pkt_close, timeout_close;
  logic [BUF_AW:0] close_len, head_len;

  tx_state_e       state_q, state_d;
  logic [BUF_AW:0] rem_q;
  logic [15:0]     byte_num_q;
  logic            pop, head_load, lq_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign buf_full = (wr_ptr_q[BUF_AW] != rd_ptr_q[BUF_AW]) &&
                    (wr_ptr_q[BUF_AW-1:0] == rd_ptr_q[BUF_AW-1:0]);
  assign lq_full  = (lq_wr_q[LEN_AW] != lq_rd_q[LEN_AW]) &&
                    (lq_wr_q[LEN_AW-1:0] == lq_rd_q[LEN_AW-1:0]);
  assign lq_empty = (lq_wr_q == lq_rd_q);

  assign in_ready = rdy_q & ~buf_full & ~lq_full;
  assign wr_fire  = in_valid & in_ready;
  assign acc_inc  = acc_q + 1'b1;
  assign head_len = lq_mem_q[lq_rd_q[LEN_AW-1:0]];

  assign pkt_close = (wr_fire && ((acc_inc == PKT_LEN) || in_last)) || timeout_close;
  assign close_len = wr_fire ? acc_inc : acc_q;

`ifdef UDP_TX_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] idle_cnt_q;

  // Saturates at the limit so a flush blocked by a full length queue retries every cycle.
  always_ff @(posedge clk) begin
    if (rst || wr_fire || (acc_q == '0)) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != TO_LAST) begin
      idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end

  assign timeout_close = !wr_fire && (acc_q != '0) && !lq_full && (idle_cnt_q == TO_LAST);
`else
  // No idle flush; TIMEOUT_CYC stays referenced so the parameter list is unchanged.
  assign timeout_close = (TIMEOUT_CYC == 0) && 1'b0;
`endif

  always_comb begin
    acc_d = acc_q;
    if (pkt_close) begin
      acc_d = '0;
    end else if (wr_fire) begin
      acc_d = acc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      acc_q    <= '0;
      lq_wr_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      acc_q <= acc_d;
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pkt_close) begin
        lq_mem_q[lq_wr_q[LEN_AW-1:0]] <= close_len;
        lq_wr_q                       <= lq_wr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!lq_empty) state_d = ST_START;
      ST_START: state_d = ST_SEND;
      ST_SEND:  if (udp_tx_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start_en = (state_q == ST_START);
    busy        = (state_q != ST_IDLE);
    head_load   = (state_q == ST_IDLE) && !lq_empty;
    pop         = (state_q == ST_SEND) && tx_req && (rem_q != '0);
    lq_pop      = (state_q == ST_DONE);
  end

  // Leaving a packet early skips its unread words by jumping the read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      lq_rd_q    <= '0;
      rem_q      <= '0;
      byte_num_q <= '0;
    end else begin
      if (head_load) begin
        byte_num_q <= words_to_bytes(16'(head_len));
        rem_q      <= head_len;
      end
      if (pop) begin
        rem_q    <= rem_q - 1'b1;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (lq_pop) begin
        lq_rd_q  <= lq_rd_q + 1'b1;
        rd_ptr_q <= rd_ptr_q + rem_q;
      end
    end
  end

  assign tx_byte_num = byte_num_q;

  udp_tx_buf #(
    .AW (BUF_AW)
  ) u_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_ptr_q[BUF_AW-1:0]),
    .wr_data_i (in_data),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q[BUF_AW-1:0]),
    .rd_data_o (tx_data)
  );

endmodule

// File: doc/udp_tx_packer.md
# udp_tx_packer

Packetizer upstream of the UDP transmit path. Accepts a continuous 32-bit word stream from the video/data pipeline, buffers it, cuts it into UDP payloads of at most `PKT_WORDS` words, and drives the UDP transmitter's start/length/request handshake (`tx_start_en`, `tx_byte_num`, `tx_req`, `tx_data`, `udp_tx_done`). Runs entirely in the GMII clock domain that also clocks the UDP/ARP stack.

## Interface
Parameters:
- `PKT_WORDS`, 256: maximum payload words per packet (1024 bytes); range 1..`2**BUF_AW`.
- `BUF_AW`, 10: data buffer address width (1024 words).
- `LEN_AW`, 2: length-queue address width (4 closed packets outstanding).
- `TIMEOUT_CYC`, 125000: idle cycles before a partial packet is flushed (only with `UDP_TX_TIMEOUT_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: GMII clock (connect to `gmii_rx_clk`).
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: input word valid.
- `in_data` in 32: input word; byte [31:24] is transmitted first.
- `in_last` in 1: closes the current packet after this word.
- `in_ready` out 1: word accepted when `in_valid & in_ready`.
- `tx_start_en` out 1: one-cycle start pulse to UDP transmitter.
- `tx_byte_num` out 16: payload bytes, = 4 × packet words.
- `tx_req` in 1: UDP transmitter requests the next word.
- `tx_data` out 32: word answering `tx_req`.
- `udp_tx_done` in 1: UDP transmitter finished the frame.
- `busy` out 1: high from `tx_start_en` until `udp_tx_done` is taken.

## Operation
- Ingress: accepted word written to the data buffer; `acc_words` increments. Packet closes when `acc_words` reaches `PKT_WORDS`, or on an accepted word with `in_last`; its length (1..`PKT_WORDS`) is pushed to the length queue and `acc_words` returns to 0.
- `in_ready` = data buffer not full AND length queue not full. If the queue is full, no word is accepted (prevents an unclosable packet).
- `in_last` together with the word that reaches `PKT_WORDS` closes exactly one packet.
- Egress FSM:
  - IDLE: length queue not empty -> latch `tx_byte_num` = 4 × head length, load `rem_words` = head length, go START.
  - START: assert `tx_start_en` for one cycle, go SEND.
  - SEND: each `tx_req` cycle with `rem_words` > 0 pops one word and decrements `rem_words`. A `tx_req` when `rem_words` = 0 pops nothing, and `tx_data` holds its value. On `udp_tx_done`, go DONE.
  - DONE: pop the length queue, discard any unpopped words of this packet (advance the read pointer by `rem_words`), go IDLE.
- `udp_tx_done` outside SEND is ignored.
- Byte count is computed in 16 bits; `PKT_WORDS` ≤ 16383.

## Timing
- Reset values: `in_ready` 0, `tx_start_en` 0, `tx_byte_num` 0, `tx_data` 0, `busy` 0.
- Reset clears buffer pointers, `acc_words`, the length queue and the FSM (to IDLE). Partial and queued packets are discarded.
- A reset mid-SEND leaves the UDP transmitter unaware. System reset drives both blocks.
- `in_ready` is high from the first cycle after reset deasserts.
- Closed packet to `tx_start_en`: 2 cycles when idle (IDLE at cycle N+1 after the closing write at N, START at N+2).
- `tx_data` is registered: valid the cycle after the `tx_req` that popped it.
- `tx_byte_num` is stable from START through DONE.
- `busy` is high START..DONE inclusive.
- Simultaneous write and pop in the same cycle is supported; full/empty flags use extra-MSB pointers.

## Configuration
- `UDP_TX_TIMEOUT_EN` defined:
  - An idle counter resets on every accepted word and counts while `acc_words` > 0.
  - At `TIMEOUT_CYC` it closes the partial packet, as if `in_last` had arrived, provided the length queue is not full; otherwise it retries each cycle.
  - A write in the timeout cycle takes precedence and restarts the counter.
- Undefined: no counter. Partial packets close only on `in_last`.

## Structure
- Shared package `udp_tx_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_START`, `ST_SEND`, `ST_DONE`).
  - Bytes-per-word constant (4).
- One sub-module, `udp_tx_buf`: simple dual-port RAM with registered read (`BUF_AW` × 32).
- The length queue is a small register array inside the top.

## Test plan
- Write 256 words 0..255, continuous -> one `tx_start_en`, `tx_byte_num` = 1024. `tx_data` = 0..255, one cycle after each `tx_req`. `busy` drops after `udp_tx_done`.
- Write 3 words with `in_last` on the third -> `tx_byte_num` = 12, 3 words returned. A 4th `tx_req` returns nothing new (`tx_data` holds 2).
- Write 600 words with `in_last` on the last -> three packets, 1024, 1024 and 352 bytes, in order with no word loss. Writing continues during SEND.
- Hold `udp_tx_done` low and keep writing -> `in_ready` falls at 1024 buffered words or at 4 queued packets. It recovers after the done pulse.
- With `UDP_TX_TIMEOUT_EN` and `TIMEOUT_CYC` = 100: write 5 words, then idle -> packet of 20 bytes starts 100 + 2 cycles after the last write. Without the macro, no start occurs.
- Assert `rst` mid-SEND -> all outputs reach their reset values on the next cycle. A new 8-word packet afterwards has `tx_byte_num` = 32 and fresh data.
